// File: rtl/instr_loader.sv
// Copies a block of source words into the OS or PROC instruction bank, one word per READ/WAIT/WRITE pass.
// Optional: define INSTR_LOADER_CHECKSUM_EN to add an XOR checksum of every written word.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dest_os,
    input  logic [DATA_WIDTH-1:0] src_base,
    input  logic [DATA_WIDTH-1:0] dst_base,
    input  logic [PAGE_WIDTH:0]   length,
    output logic                  src_rd,
    output logic [DATA_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  write_flag,
    output logic                  write_os,
    output logic [DATA_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] input_instr,
    output logic                  busy,
    output logic                  done,
    output logic                  error
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [DATA_WIDTH:0] BANK_WORDS = {{DATA_WIDTH{1'b0}}, 1'b1} << PAGE_WIDTH;
    localparam logic [PAGE_WIDTH:0] CNT_ONE    = {{PAGE_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [PAGE_WIDTH:0]   count_q, count_d;
    logic [PAGE_WIDTH:0]   length_q, length_d;
    logic                  dest_os_q, dest_os_d;
    logic [DATA_WIDTH-1:0] src_base_q, src_base_d;
    logic [DATA_WIDTH-1:0] dst_base_q, dst_base_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wos_q, wos_d;
    logic [DATA_WIDTH-1:0] waddr_q, waddr_d;

    logic [DATA_WIDTH:0]   end_sum;
    logic [DATA_WIDTH-1:0] cnt_ext;

    // One extra bit so a dst_base near the top of the address space cannot wrap into range.
    assign end_sum = {1'b0, dst_base} + {{(DATA_WIDTH-PAGE_WIDTH){1'b0}}, length};
    assign cnt_ext = {{(DATA_WIDTH-PAGE_WIDTH-1){1'b0}}, count_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            length_q   <= '0;
            dest_os_q  <= 1'b0;
            src_base_q <= '0;
            dst_base_q <= '0;
            data_q     <= '0;
            wos_q      <= 1'b0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            length_q   <= length_d;
            dest_os_q  <= dest_os_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            data_q     <= data_d;
            wos_q      <= wos_d;
            waddr_q    <= waddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        length_d   = length_q;
        dest_os_d  = dest_os_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        data_d     = data_q;
        wos_d      = wos_q;
        waddr_d    = waddr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dest_os_d  = dest_os;
                    src_base_d = src_base;
                    dst_base_d = dst_base;
                    length_d   = length;
                    count_d    = '0;
                    if (length == '0)             state_d = S_DONE;
                    else if (end_sum > BANK_WORDS) state_d = S_ERR;
                    else                           state_d = S_READ;
                end
            end
            S_READ:  state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (src_valid) begin
                    // Write-port registers are loaded here so WRITE drives them straight from flops.
                    data_d  = src_data;
                    wos_d   = dest_os_q;
                    waddr_d = dst_base_q + cnt_ext;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + CNT_ONE;
                if (abort)                            state_d = S_IDLE;
                else if (count_q + CNT_ONE == length_q) state_d = S_DONE;
                else                                  state_d = S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign src_rd       = (state_q == S_READ);
    assign src_addr     = src_rd ? (src_base_q + cnt_ext) : '0;
    assign write_flag   = (state_q == S_WRITE);
    assign write_os     = wos_q;
    assign read_address = waddr_q;
    assign input_instr  = data_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) checksum_d = '0;
        else if (state_q == S_WRITE)    checksum_d = checksum_q ^ data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    // Checksum port and register are not built.
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized transfers against an arithmetic model of the loader's timing and data flow.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dest_os = 1'b0;
    logic [31:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [10:0] length = '0;
    logic        src_rd;
    logic [31:0] src_addr;
    logic [31:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        write_flag;
    logic        write_os;
    logic [31:0] read_address;
    logic [31:0] input_instr;
    logic        busy;
    logic        done;
    logic        error;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    instr_loader #(.DATA_WIDTH(32), .PAGE_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dest_os(dest_os),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data), .src_valid(src_valid),
        .write_flag(write_flag), .write_os(write_os), .read_address(read_address),
        .input_instr(input_instr), .busy(busy), .done(done), .error(error)
`ifdef INSTR_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc = 0;
    int rsp_lat = 1;
    int rsp_wait = 0;
    logic spur_en = 1'b0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] srcmem [0:4095];

    logic [31:0] wl_addr[$];
    logic [31:0] wl_data[$];
    logic        wl_os[$];
    logic [31:0] rl_addr[$];
    int          done_q[$];
    int          err_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Source memory: answers each read rsp_lat cycles later; optionally shouts garbage during READ.
    always begin
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        if (rsp_wait > 0) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
                src_valid = 1'b1;
                src_data  = srcmem[rsp_addr[11:0]];
            end
        end
        if (src_rd) begin
            rsp_addr = src_addr;
            rsp_wait = rsp_lat;
            if (spur_en) begin
                src_valid = 1'b1;
                src_data  = 32'hDEADBEEF;
            end
        end
    end

    always @(negedge clk) begin
        if (write_flag) begin
            wl_addr.push_back(read_address);
            wl_data.push_back(input_instr);
            wl_os.push_back(write_os);
        end
        if (src_rd) rl_addr.push_back(src_addr);
        if (done)   done_q.push_back(cyc - acc + 1);
        if (error)  err_q.push_back(cyc - acc + 1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return {26'd0, src_rd, src_addr, write_flag, write_os, read_address, input_instr,
                busy, done, error};
    endfunction

    task automatic run_xfer(input string name, input logic os, input logic [31:0] src,
                            input logic [31:0] dst, input int len, input int lat,
                            input int abort_rel);
        int wb, rb, db, eb, nw, nr, per, budget, exp_done, exp_err, done_rel;
        logic finished;
        logic [31:0] exp_sum;
        wb = wl_addr.size(); rb = rl_addr.size(); db = done_q.size(); eb = err_q.size();
        per = lat + 2;
        exp_err = (len != 0 && (longint'({32'd0, dst}) + longint'(len) > 1024)) ? 1 : 0;
        if (len == 0 || exp_err == 1) begin
            nw = 0; nr = 0; exp_done = (len == 0) ? 1 : 0; done_rel = 1;
        end else if (abort_rel > 0) begin
            nw = (abort_rel / per < len) ? abort_rel / per : len;
            nr = ((abort_rel - 1) / per + 1 < len) ? (abort_rel - 1) / per + 1 : len;
            exp_done = 0; done_rel = 0;
        end else begin
            nw = len; nr = len; exp_done = 1; done_rel = len * per + 1;
        end
        rsp_lat = lat;
        budget = len * per + 12;
        @(posedge clk);
        #1;
        dest_os = os; src_base = src; dst_base = dst; length = 11'(len); start = 1'b1;
        acc = cyc + 1;
        finished = 1'b0;
        for (int r = 1; r <= budget; r++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (r == 1) check({name, " checksum cleared"}, checksum, 0);
`endif
            // Held start with fresh operands must not disturb the running transfer.
            dest_os = 1'($urandom()); src_base = $urandom(); dst_base = $urandom();
            length = 11'($urandom());
            abort = (r == abort_rel);
        end
        start = 1'b0;
        abort = 1'b0;
        check({name, " finished"}, finished, 1);
        check({name, " writes"}, wl_addr.size() - wb, nw);
        check({name, " reads"}, rl_addr.size() - rb, nr);
        exp_sum = '0;
        for (int i = 0; i < nw && wb + i < wl_addr.size(); i++) begin
            check($sformatf("%s wr%0d", name, i), {wl_os[wb+i], wl_addr[wb+i], wl_data[wb+i]},
                  {os, dst + 32'(i), srcmem[12'(src + 32'(i))]});
            exp_sum ^= srcmem[12'(src + 32'(i))];
        end
        for (int i = 0; i < nr && rb + i < rl_addr.size(); i++)
            check($sformatf("%s rd%0d", name, i), rl_addr[rb+i], src + 32'(i));
        check({name, " done count"}, done_q.size() - db, exp_done);
        if (exp_done == 1 && done_q.size() > db) check({name, " done cycle"}, done_q[db], done_rel);
        check({name, " error count"}, err_q.size() - eb, exp_err);
        if (exp_err == 1 && err_q.size() > eb) check({name, " error cycle"}, err_q[eb], 1);
        check({name, " idle busy"}, busy, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check({name, " checksum"}, checksum, exp_sum);
`endif
    endtask

    initial begin
        int len, lat, ab, wb;
        logic [31:0] dst, src;
        for (int i = 0; i < 4096; i++) srcmem[i] = $urandom();
        for (int i = 0; i < 4; i++) srcmem[12'h100 + i] = 32'hA000_0100 + 32'(i);
        srcmem[12'h200] = 32'h1; srcmem[12'h201] = 32'h2;
        srcmem[12'h202] = 32'h4; srcmem[12'h203] = 32'h8;

        @(posedge clk);
        #1;
        check("reset outputs", outs_vec(), 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("reset checksum", checksum, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset idle", outs_vec(), 0);

        run_xfer("nominal", 1'b1, 32'h100, 32'd0, 4, 1, 0);
        run_xfer("proc slow", 1'b0, 32'h340, 32'd77, 2, 5, 0);
        run_xfer("overrange", 1'b1, 32'h10, 32'd1020, 5, 1, 0);
        run_xfer("zero len", 1'b0, 32'h10, 32'd5, 0, 1, 0);
        run_xfer("top fit", 1'b1, 32'h500, 32'd1020, 4, 2, 0);
        run_xfer("abort wr1", 1'b1, 32'h600, 32'd40, 4, 1, 6);
        run_xfer("dst wrap", 1'b0, 32'h10, 32'hFFFF_FFFF, 1, 1, 0);
        run_xfer("checksum", 1'b1, 32'h200, 32'd8, 4, 1, 0);
        run_xfer("after sum", 1'b0, 32'h700, 32'd100, 3, 1, 0);

        // Reset while the loader waits on a slow source.
        wb = wl_addr.size();
        rsp_lat = 5;
        @(posedge clk);
        #1;
        dest_os = 1'b1; src_base = 32'h800; dst_base = 32'd9; length = 11'd3; start = 1'b1;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset in wait outputs", outs_vec(), 0);
        check("reset in wait writes", wl_addr.size() - wb, 0);
        run_xfer("after reset", 1'b1, 32'h900, 32'd200, 3, 1, 0);

        spur_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 12);
            lat = $urandom_range(1, 4);
            src = 32'($urandom_range(0, 4000));
            if ($urandom_range(0, 3) == 0) dst = 32'($urandom_range(1024 - len + 1, 1100));
            else                           dst = 32'($urandom_range(0, 1024 - len));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len * (lat + 2)) : 0;
            run_xfer($sformatf("rand%0d", k), 1'($urandom()), src, dst, len, lat, ab);
        end
        spur_en = 1'b0;

        run_xfer("full bank", 1'b0, 32'h0, 32'd0, 1024, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
